// File: rtl/shiftreg_pkg.sv
// Shared defaults, FSM encoding and count sizing for the configuration shift-register loader.
package shiftreg_pkg;

    localparam int unsigned SizeDynDefault  = 16;
    localparam int unsigned SizeStatDefault = 88;

    typedef enum logic [1:0] {
        StIdle,
        StShiftDyn,
        StShiftStat,
        StHold
    } state_e;

    // Room for counts 0..size+1 so the saturation value never wraps.
    function automatic int unsigned cnt_width(input int unsigned size);
        return $clog2(size + 2);
    endfunction

endpackage

// File: rtl/sr_capture.sv
// One configuration channel: serial shift register, saturating bit counter and a
// shadow register that latches the shifted word with a one-cycle valid pulse.
module sr_capture
    import shiftreg_pkg::*;
#(
    parameter int unsigned Size = SizeDynDefault,
    parameter int unsigned CntW = cnt_width(SizeStatDefault)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            shift_i,
    input  logic            latch_i,
    input  logic            bit_i,
    output logic [Size-1:0] cfg_o,
    output logic            valid_o,
    output logic            cnt_ok_o
);

    localparam logic [CntW-1:0] SizeCnt = CntW'(Size);
    localparam logic [CntW-1:0] SatCnt  = CntW'(Size + 1);

    logic [Size-1:0] sr_q, sr_d;
    logic [Size-1:0] cfg_q, cfg_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            valid_q, valid_d;

    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
        valid_d = latch_i;
        if (start_i || shift_i) begin
            sr_d = {sr_q[Size-2:0], bit_i};
        end
        // A fresh sequence restarts at 1; stale register bits are shifted out naturally.
        if (start_i) begin
            cnt_d = CntW'(1);
        end else if (shift_i && (cnt_q != SatCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (latch_i) begin
            cfg_d = sr_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            cfg_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
            valid_q <= valid_d;
        end
    end

    assign cfg_o    = cfg_q;
    assign valid_o  = valid_q;
    assign cnt_ok_o = (cnt_q == SizeCnt);

endmodule

// File: rtl/shift_reg_loader.sv
// Loads dynamic and static configuration words from a shared serial line; the FSM steers
// one capture channel at a time and flags length or select-protocol errors.
module shift_reg_loader
    import shiftreg_pkg::*;
#(
    parameter int unsigned SIZESRDYN  = SizeDynDefault,
    parameter int unsigned SIZESRSTAT = SizeStatDefault
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  sel_dyn,
    input  logic                  sel_stat,
    input  logic                  en_fin,
    input  logic                  signal_out,
    input  logic                  err_clr,
    output logic [SIZESRDYN-1:0]  dyn_cfg,
    output logic [SIZESRSTAT-1:0] stat_cfg,
    output logic                  dyn_valid,
    output logic                  stat_valid,
    output logic                  len_err,
    output logic                  busy
);

    localparam int unsigned SizeMax = (SIZESRSTAT > SIZESRDYN) ? SIZESRSTAT : SIZESRDYN;
    localparam int unsigned CntW    = cnt_width(SizeMax);

    state_e state_q, state_d;
    logic   len_err_q, len_err_d;
    logic   act_dyn, act_stat;
    logic   start_dyn, shift_dyn, latch_dyn, dyn_cnt_ok;
    logic   start_stat, shift_stat, latch_stat, stat_cnt_ok;
    logic   err_set;

    assign act_dyn  = sel_dyn & ~sel_stat & ~en_fin;
    assign act_stat = sel_stat & ~sel_dyn & ~en_fin;

    always_comb begin
        state_d    = state_q;
        start_dyn  = 1'b0;
        shift_dyn  = 1'b0;
        latch_dyn  = 1'b0;
        start_stat = 1'b0;
        shift_stat = 1'b0;
        latch_stat = 1'b0;
        err_set    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (act_dyn) begin
                    start_dyn = 1'b1;
                    state_d   = StShiftDyn;
                end else if (act_stat) begin
                    start_stat = 1'b1;
                    state_d    = StShiftStat;
                end else if (en_fin) begin
                    state_d = StHold;
                end
                if (sel_dyn && sel_stat) begin
                    err_set = 1'b1;
                end
            end
            StShiftDyn: begin
                if (act_dyn) begin
                    shift_dyn = 1'b1;
                end else begin
                    // Exit cycle: its serial bit is never shifted, whatever caused the exit.
                    latch_dyn = dyn_cnt_ok;
                    err_set   = ~dyn_cnt_ok;
                    state_d   = en_fin ? StHold : StIdle;
                end
            end
            StShiftStat: begin
                if (act_stat) begin
                    shift_stat = 1'b1;
                end else begin
                    latch_stat = stat_cnt_ok;
                    err_set    = ~stat_cnt_ok;
                    state_d    = en_fin ? StHold : StIdle;
                end
            end
            StHold: begin
                if (!en_fin) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Setting wins over a simultaneous clear.
    always_comb begin
        len_err_d = len_err_q;
        if (err_set) begin
            len_err_d = 1'b1;
        end else if (err_clr) begin
            len_err_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_err_q <= len_err_d;
        end
    end

    sr_capture #(
        .Size (SIZESRDYN),
        .CntW (CntW)
    ) u_dyn (
        .clk_i    (CLK),
        .rst_i    (RST),
        .start_i  (start_dyn),
        .shift_i  (shift_dyn),
        .latch_i  (latch_dyn),
        .bit_i    (signal_out),
        .cfg_o    (dyn_cfg),
        .valid_o  (dyn_valid),
        .cnt_ok_o (dyn_cnt_ok)
    );

    sr_capture #(
        .Size (SIZESRSTAT),
        .CntW (CntW)
    ) u_stat (
        .clk_i    (CLK),
        .rst_i    (RST),
        .start_i  (start_stat),
        .shift_i  (shift_stat),
        .latch_i  (latch_stat),
        .bit_i    (signal_out),
        .cfg_o    (stat_cfg),
        .valid_o  (stat_valid),
        .cnt_ok_o (stat_cnt_ok)
    );

    assign len_err = len_err_q;
    assign busy    = (state_q == StShiftDyn) || (state_q == StShiftStat);

endmodule

// File: tb/tb_shift_reg_loader.sv
// Directed bench for shift_reg_loader: a table of serial loads plus hand-written
// sequences for select conflicts, the locked state, exit by opposite select and reset.
module tb_shift_reg_loader;

    logic         CLK;
    logic         RST;
    logic         sel_dyn;
    logic         sel_stat;
    logic         en_fin;
    logic         signal_out;
    logic         err_clr;
    logic [15:0]  dyn_cfg;
    logic [87:0]  stat_cfg;
    logic         dyn_valid;
    logic         stat_valid;
    logic         len_err;
    logic         busy;

    int unsigned n_total;
    int unsigned n_pass;

    shift_reg_loader #(
        .SIZESRDYN  (16),
        .SIZESRSTAT (88)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .sel_dyn    (sel_dyn),
        .sel_stat   (sel_stat),
        .en_fin     (en_fin),
        .signal_out (signal_out),
        .err_clr    (err_clr),
        .dyn_cfg    (dyn_cfg),
        .stat_cfg   (stat_cfg),
        .dyn_valid  (dyn_valid),
        .stat_valid (stat_valid),
        .len_err    (len_err),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic         is_stat;
        int unsigned  n;
        logic [127:0] data;
        logic         ok;
        logic [127:0] exp_dyn;
        logic [127:0] exp_stat;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Shifts n bits of data MSB first under the chosen select; stops before the exit cycle.
    task automatic shift_bits(input logic is_stat, input int unsigned n,
                              input logic [127:0] data);
        for (int i = 0; i < int'(n); i++) begin
            sel_dyn    = ~is_stat;
            sel_stat   = is_stat;
            signal_out = data[n - 1 - i];
            tick();
        end
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", {127'b0, len_err}, 128'h0);
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        sel_dyn    = 1'b0;
        sel_stat   = 1'b0;
        en_fin     = 1'b0;
        signal_out = 1'b0;
        err_clr    = 1'b0;

        vecs[0] = '{1'b0, 16, 128'h8001, 1'b1, 128'h8001, 128'h0};
        vecs[1] = '{1'b0, 15, 128'h1234, 1'b0, 128'h8001, 128'h0};
        vecs[2] = '{1'b0, 16, 128'hA5C3, 1'b1, 128'hA5C3, 128'h0};
        vecs[3] = '{1'b0, 17, 128'h1FFFF, 1'b0, 128'hA5C3, 128'h0};
        vecs[4] = '{1'b1, 88, 128'hAAAAAAAAAAAAAAAAAAAAAA, 1'b1, 128'hA5C3,
                    128'hAAAAAAAAAAAAAAAAAAAAAA};
        vecs[5] = '{1'b1, 89, 128'h1555555555555555555555, 1'b0, 128'hA5C3,
                    128'hAAAAAAAAAAAAAAAAAAAAAA};
        vecs[6] = '{1'b1, 88, 128'h0123456789ABCDEF012345, 1'b1, 128'hA5C3,
                    128'h0123456789ABCDEF012345};
        vecs[7] = '{1'b0, 1, 128'h1, 1'b0, 128'hA5C3, 128'h0123456789ABCDEF012345};

        // Reset is asynchronous: outputs must clear before any clock edge.
        RST = 1'b1;
        #2;
        check("rst_dyn_cfg", 128'(dyn_cfg), 128'h0);
        check("rst_stat_cfg", 128'(stat_cfg), 128'h0);
        check("rst_flags", {124'b0, dyn_valid, stat_valid, len_err, busy}, 128'h0);
        tick();
        RST = 1'b0;
        tick();

        for (int v = 0; v < 8; v++) begin
            shift_bits(vecs[v].is_stat, vecs[v].n, vecs[v].data);
            check($sformatf("v%0d_busy", v), {127'b0, busy}, 128'h1);
            check($sformatf("v%0d_no_early_valid", v), {126'b0, dyn_valid, stat_valid}, 128'h0);
            sel_dyn    = 1'b0;
            sel_stat   = 1'b0;
            signal_out = 1'b0;
            tick();
            check($sformatf("v%0d_dyn_cfg", v), 128'(dyn_cfg), vecs[v].exp_dyn);
            check($sformatf("v%0d_stat_cfg", v), 128'(stat_cfg), vecs[v].exp_stat);
            check($sformatf("v%0d_valids", v), {126'b0, dyn_valid, stat_valid},
                  vecs[v].ok ? (vecs[v].is_stat ? 128'h1 : 128'h2) : 128'h0);
            check($sformatf("v%0d_len_err", v), {127'b0, len_err}, {127'b0, ~vecs[v].ok});
            check($sformatf("v%0d_busy_after", v), {127'b0, busy}, 128'h0);
            tick();
            check($sformatf("v%0d_pulse_end", v), {126'b0, dyn_valid, stat_valid}, 128'h0);
            check($sformatf("v%0d_err_sticky", v), {127'b0, len_err}, {127'b0, ~vecs[v].ok});
            clear_err();
        end

        // Both selects together in IDLE: protocol error, nothing loads.
        sel_dyn    = 1'b1;
        sel_stat   = 1'b1;
        signal_out = 1'b1;
        tick();
        check("both_err", {127'b0, len_err}, 128'h1);
        check("both_busy", {127'b0, busy}, 128'h0);
        tick();
        tick();
        sel_dyn  = 1'b0;
        sel_stat = 1'b0;
        tick();
        check("both_dyn_cfg", 128'(dyn_cfg), 128'hA5C3);
        check("both_stat_cfg", 128'(stat_cfg), 128'h0123456789ABCDEF012345);
        // Set wins when err_clr coincides with a new error.
        sel_dyn  = 1'b1;
        sel_stat = 1'b1;
        err_clr  = 1'b1;
        tick();
        sel_dyn  = 1'b0;
        sel_stat = 1'b0;
        err_clr  = 1'b0;
        check("set_wins", {127'b0, len_err}, 128'h1);
        clear_err();

        // Locked: 128 cycles of select activity must do nothing.
        begin
            int unsigned bad;
            bad    = 0;
            en_fin = 1'b1;
            for (int i = 0; i < 128; i++) begin
                sel_dyn    = 1'b1;
                signal_out = i[0];
                tick();
                if (busy || dyn_valid || stat_valid || len_err) bad++;
            end
            check("hold_quiet_cycles", 128'(bad), 128'h0);
            sel_dyn = 1'b0;
            tick();
            check("hold_dyn_cfg", 128'(dyn_cfg), 128'hA5C3);
            en_fin = 1'b0;
            tick();
            check("hold_release_busy", {127'b0, busy}, 128'h0);
        end

        // Exit by the opposite select: the exit-cycle bit must not be shifted in.
        shift_bits(1'b0, 16, 128'h00FF);
        sel_dyn    = 1'b0;
        sel_stat   = 1'b1;
        signal_out = 1'b1;
        tick();
        sel_stat   = 1'b0;
        signal_out = 1'b0;
        check("opp_dyn_cfg", 128'(dyn_cfg), 128'h00FF);
        check("opp_valids", {126'b0, dyn_valid, stat_valid}, 128'h2);
        check("opp_stat_cfg", 128'(stat_cfg), 128'h0123456789ABCDEF012345);
        tick();
        check("opp_idle", {126'b0, busy, len_err}, 128'h0);

        // Reset mid-shift discards the partial load.
        shift_bits(1'b0, 8, 128'hFF);
        RST = 1'b1;
        #2;
        check("midrst_cfgs", 128'(dyn_cfg) | 128'(stat_cfg), 128'h0);
        check("midrst_flags", {124'b0, dyn_valid, stat_valid, len_err, busy}, 128'h0);
        sel_dyn = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        shift_bits(1'b0, 16, 128'h1234);
        sel_dyn = 1'b0;
        tick();
        check("post_rst_dyn_cfg", 128'(dyn_cfg), 128'h1234);
        check("post_rst_flags", {125'b0, dyn_valid, stat_valid, len_err}, 128'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
